chunked_addsub: RTL and testbench

//  Multi-cycle, parametrised ripple-carry adder/subtractor; next generation of the 8-bit ripple adder.
//  - Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, through one CHUNK-bit ripple slice.
//  - Carry is held in a register between chunks.
//  - Valid/ready handshake on input and output; sits between datapath operand registers and the result bus.
//  - Trades latency for area on wide operands.

---
 rtl/chunked_addsub_if.sv | 24 ++
 rtl/chunked_addsub.sv | 89 ++++++++
 tb/tb_chunked_addsub.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_addsub_if.sv
// Operand/result handshake bundle for the chunked adder/subtractor.
interface chunked_addsub_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle ripple adder/subtractor: one CHUNK-bit slice reused N=WIDTH/CHUNK times,
// carry held in a register between chunks.
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    chunked_addsub_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               carry_q, cout_q, ovf_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CHUNK-1:0]   a_ch, b_ch, s_ch;
    logic               c_out, c_msb, last;

    // Operands shift right each RUN cycle so the slice always sees the low chunk.
    assign a_ch = a_q[CHUNK-1:0];
    assign b_ch = b_q[CHUNK-1:0];
    assign {c_out, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from its sum bit and operand bits.
    assign c_msb = s_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    assign last  = (idx_q == IDX_W'(N - 1));

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract as a + ~b + ~cin.
                        a_q     <= bus.a;
                        b_q     <= bus.b ^ {WIDTH{bus.sub}};
                        carry_q <= bus.cin ^ bus.sub;
                        sum_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx_q*CHUNK +: CHUNK] <= s_ch;
                    carry_q <= c_out;
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        cout_q <= c_out;
                        ovf_q  <= c_msb ^ c_out;
                        idx_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: three instances (32/8, 8/8, 16/4) share one stimulus path
// selected by sel; results checked through an expected-value queue.
module tb_chunked_addsub;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic        dv, dcin, dsub, dordy;
    logic [31:0] da, db;
    logic        r_in_ready, r_out_valid, r_cout, r_ovf;
    logic [31:0] r_sum;

    res_t        sb[$];
    res_t        nxt_exp;
    int          n_cmp = 0, n_err = 0, n_pop = 0;
    int          cycle = 0, acc_edge = 0, last_rise = -1;
    logic        prev_ov = 1'b0, b2b = 1'b0;

    always #5 clk = ~clk;

    chunked_addsub_if #(.WIDTH(32)) i0 ();
    chunked_addsub_if #(.WIDTH(8))  i1 ();
    chunked_addsub_if #(.WIDTH(16)) i2 ();

    assign i0.in_valid = dv && (sel == 0);
    assign i0.a = da;        assign i0.b = db;
    assign i0.cin = dcin;    assign i0.sub = dsub;  assign i0.out_ready = dordy;
    assign i1.in_valid = dv && (sel == 1);
    assign i1.a = da[7:0];   assign i1.b = db[7:0];
    assign i1.cin = dcin;    assign i1.sub = dsub;  assign i1.out_ready = dordy;
    assign i2.in_valid = dv && (sel == 2);
    assign i2.a = da[15:0];  assign i2.b = db[15:0];
    assign i2.cin = dcin;    assign i2.sub = dsub;  assign i2.out_ready = dordy;

    chunked_addsub #(.WIDTH(32), .CHUNK(8)) u0 (.clk(clk), .rst(rst), .bus(i0));
    chunked_addsub #(.WIDTH(8),  .CHUNK(8)) u1 (.clk(clk), .rst(rst), .bus(i1));
    chunked_addsub #(.WIDTH(16), .CHUNK(4)) u2 (.clk(clk), .rst(rst), .bus(i2));

    always_comb begin
        r_in_ready  = 1'b0;
        r_out_valid = 1'b0;
        r_sum       = '0;
        r_cout      = 1'b0;
        r_ovf       = 1'b0;
        case (sel)
            0: begin r_in_ready = i0.in_ready; r_out_valid = i0.out_valid;
                     r_sum = i0.sum; r_cout = i0.cout; r_ovf = i0.ovf; end
            1: begin r_in_ready = i1.in_ready; r_out_valid = i1.out_valid;
                     r_sum = {24'b0, i1.sum}; r_cout = i1.cout; r_ovf = i1.ovf; end
            2: begin r_in_ready = i2.in_ready; r_out_valid = i2.out_valid;
                     r_sum = {16'b0, i2.sum}; r_cout = i2.cout; r_ovf = i2.ovf; end
            default: ;
        endcase
    end

    function automatic int w_cur();
        return (sel == 0) ? 32 : (sel == 1) ? 8 : 16;
    endfunction

    function automatic int n_cur();
        return (sel == 1) ? 1 : 4;
    endfunction

    // Reference: full-width add, overflow from operand/result signs.
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        res_t        r;
        logic [31:0] mask, am, bm;
        logic [32:0] full;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am     = a & mask;
        bm     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bm} + {32'b0, cin ^ sub};
        r.sum  = full[31:0] & mask;
        r.cout = full[w];
        r.ovf  = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (sel %0d, cycle %0d): got %h want %h", name, sel, cycle, act, exp);
        end
    endtask

    task automatic pop_cmp();
        res_t e;
        n_pop++;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_result (sel %0d): got sum %h with empty queue", sel, r_sum);
        end else begin
            e = sb.pop_front();
            chk("sum",  r_sum,         e.sum);
            chk("cout", 32'(r_cout),   32'(e.cout));
            chk("ovf",  32'(r_ovf),    32'(e.ovf));
        end
    endtask

    // One rising edge with the inputs currently driven; predicts accept/handshake first.
    task automatic cyc();
        if (r_out_valid && !prev_ov) begin
            chk("latency", 32'(cycle - acc_edge), 32'(n_cur()));
            if (b2b && last_rise >= 0) chk("period", 32'(cycle - last_rise), 32'(n_cur() + 2));
            last_rise = cycle;
        end
        prev_ov = r_out_valid;
        if (rst) sb.delete();
        else begin
            if (r_out_valid && dordy) pop_cmp();
            if (r_in_ready && dv) begin
                sb.push_back(nxt_exp);
                acc_edge = cycle + 1;
            end
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic set_sel(input int s);
        sel = s;
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input res_t e);
        da = a; db = b; dcin = cin; dsub = sub; nxt_exp = e; dv = 1'b1;
        for (int i = 0; i < 20 && !r_in_ready; i++) cyc();
        if (!r_in_ready) chk("issue_timeout", 32'(r_in_ready), 32'd1);
        cyc();
        dv = 1'b0;
    endtask

    task automatic wait_ov();
        for (int i = 0; i < 40 && !r_out_valid; i++) cyc();
        if (!r_out_valid) chk("result_timeout", 32'(r_out_valid), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input res_t e);
        dordy = 1'b1;
        issue(a, b, cin, sub, e);
        wait_ov();
        cyc();
    endtask

    task automatic run_model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                             input logic sub);
        run_op(a, b, cin, sub, model(w_cur(), a, b, cin, sub));
    endtask

    // in_valid and out_ready tied high, fresh random operands at every accept.
    task automatic b2b_run(input int nops);
        int          issued = 0;
        int          pop0;
        logic [31:0] a, b;
        logic        cin, sub;
        pop0 = n_pop; b2b = 1'b1; last_rise = -1; dordy = 1'b1;
        for (int c = 0; c < nops * (n_cur() + 2) + 20 &&
                        (issued < nops || sb.size() > 0 || r_out_valid); c++) begin
            if (r_in_ready && issued < nops) begin
                a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
                da = a; db = b; dcin = cin; dsub = sub;
                nxt_exp = model(w_cur(), a, b, cin, sub);
                dv = 1'b1;
                issued++;
            end else if (issued >= nops) dv = 1'b0;
            cyc();
        end
        dv = 1'b0;
        b2b = 1'b0;
        chk("b2b_count", 32'(n_pop - pop0), 32'(nops));
    endtask

    initial begin
        vec_t        vt[10];
        logic [31:0] held_sum;
        logic        held_cout, held_ovf;
        int          ov_seen;

        vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}};
        vt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}};
        vt[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}};
        vt[3] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, '{32'h0000_0007, 1'b0, 1'b0}};
        vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1}};
        vt[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, '{32'h0000_0006, 1'b1, 1'b0}};
        vt[6] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, '{32'h2345_678A, 1'b0, 1'b0}};
        vt[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0}};
        vt[8] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0}};
        vt[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1}};

        rst = 1'b1; dv = 1'b0; dcin = 1'b0; dsub = 1'b0; dordy = 1'b1;
        da = '0; db = '0; nxt_exp = '0;
        set_sel(0);
        @(negedge clk);
        cyc(); cyc();
        rst = 1'b0;

        // Reset state on every instance.
        for (int s = 0; s < 3; s++) begin
            set_sel(s);
            chk("rst_in_ready",  32'(r_in_ready),  32'd1);
            chk("rst_out_valid", 32'(r_out_valid), 32'd0);
            chk("rst_sum",       r_sum,            32'd0);
            chk("rst_cout",      32'(r_cout),      32'd0);
            chk("rst_ovf",       32'(r_ovf),       32'd0);
        end

        // Directed table on the 32/8 instance.
        set_sel(0);
        for (int i = 0; i < 10; i++) run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].exp);

        // Result held while out_ready is low and inputs wiggle.
        dordy = 1'b0;
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1});
        wait_ov();
        held_sum = r_sum; held_cout = r_cout; held_ovf = r_ovf;
        chk("hold_first_sum", held_sum, 32'h8000_0000);
        for (int i = 0; i < 10; i++) begin
            da = $urandom; db = $urandom; dv = 1'($urandom); dsub = 1'($urandom);
            cyc();
            chk("hold_sum",       r_sum,            held_sum);
            chk("hold_cout",      32'(r_cout),      32'(held_cout));
            chk("hold_ovf",       32'(r_ovf),       32'(held_ovf));
            chk("hold_in_ready",  32'(r_in_ready),  32'd0);
            chk("hold_out_valid", 32'(r_out_valid), 32'd1);
        end
        dv = 1'b0; dordy = 1'b1;
        cyc();
        chk("release_out_valid", 32'(r_out_valid), 32'd0);
        chk("release_sum",       r_sum,            held_sum);

        // Reset at RUN chunk 2 discards the operation.
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, '{32'h3333_3333, 1'b0, 1'b0});
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_in_ready",  32'(r_in_ready),  32'd1);
        chk("abort_out_valid", 32'(r_out_valid), 32'd0);
        chk("abort_sum",       r_sum,            32'd0);
        chk("abort_cout",      32'(r_cout),      32'd0);
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin cyc(); if (r_out_valid) ov_seen++; end
        chk("abort_no_out_valid", 32'(ov_seen), 32'd0);

        // Reset wins over a simultaneous in_valid.
        da = 32'h5; db = 32'h6; dv = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0; dv = 1'b0;
        chk("rst_vs_valid_idle", 32'(r_in_ready), 32'd1);
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin cyc(); if (r_out_valid) ov_seen++; end
        chk("rst_vs_valid_no_result", 32'(ov_seen), 32'd0);
        run_op(32'h3, 32'h4, 1'b0, 1'b0, '{32'h7, 1'b0, 1'b0});

        b2b_run(100);

        // Degenerate N=1 and narrow 16/4 instances.
        set_sel(1);
        run_model(32'hFF, 32'h01, 1'b0, 1'b0);
        run_model(32'h7F, 32'h01, 1'b0, 1'b0);
        run_model(32'h05, 32'h07, 1'b0, 1'b1);
        b2b_run(30);
        set_sel(2);
        run_model(32'hFFFF, 32'h0001, 1'b0, 1'b0);
        run_model(32'h7FFF, 32'h0001, 1'b0, 1'b0);
        run_model(32'h0005, 32'h0007, 1'b0, 1'b1);
        b2b_run(30);

        chk("queue_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
